conv_gemm_unit: RTL and testbench

Streaming int8 matrix-multiply engine behind the DMA S2MM/MM2S AXI-Stream pair. It loads a weight matrix B (K×N) and then streams activation rows A (M×K). For each row it emits the N int32 dot products C[m][n] = Σk A[m][k]·B[k][n]. Only GEMM mode (`Control_Switch_Conv`=0) is implemented; the Img2Col convolution front-end lives elsewhere.

---
 rtl/conv_gemm_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_conv_gemm_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_gemm_unit.sv
// conv_gemm_unit: streaming int8 GEMM engine on an AXI-Stream pair.
// Loads a K x N weight matrix, then streams M activation rows.
// Each row produces N int32 dot products, sign-extended to 64 bits.
module conv_gemm_unit #(
    parameter int WBUF_DEPTH = 256,
    parameter int ROW_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Control_start,
    input  logic        Control_Switch_Conv,
    input  logic [15:0] Img2Col_OutFeature_Channel,
    input  logic [15:0] Img2Col_WeightMatrix_Row,
    input  logic [15:0] Img2Col_OutMatrix_Col,
    input  logic [15:0] Img2Col_OutMatrix_Row,
    input  logic [15:0] GemmInstru_WIDTH,
    input  logic [15:0] GemmInstru_HEIGHT,
    input  logic [63:0] s_axis_s2mm_tdata,
    input  logic        s_axis_s2mm_tvalid,
    output logic        s_axis_s2mm_tready,
    output logic [63:0] m_axis_mm2s_tdata,
    output logic        m_axis_mm2s_tvalid,
    input  logic        m_axis_mm2s_tready,
    output logic [7:0]  m_axis_mm2s_tkeep,
    output logic        m_axis_mm2s_tlast
);

    localparam int AW = $clog2(WBUF_DEPTH);
    localparam int RW = $clog2(ROW_DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD_W   = 2'd1;
    localparam logic [1:0] S_LOAD_ROW = 2'd2;
    localparam logic [1:0] S_COMPUTE  = 2'd3;

    logic [1:0]         state;

    // Latched job configuration (K is kept as a count of 64-bit beats).
    logic [15:0]        w_n;
    logic [12:0]        w_k8;
    logic [15:0]        o_n;
    logic [12:0]        a_k8;
    logic [15:0]        m_rows;

    logic [12:0]        kcnt;
    logic [15:0]        ncnt;
    logic [15:0]        mcnt;
    logic [AW-1:0]      addr;
    logic               drain;
    logic signed [31:0] acc;

    logic               out_valid;
    logic               out_last;
    logic [63:0]        out_data;

    logic [63:0]        wbuf [WBUF_DEPTH];
    logic [63:0]        rbuf [ROW_DEPTH];

    logic               in_hs;
    logic               out_hs;
    logic               w_last_k;
    logic               a_last_k;
    logic               n_last;
    logic               m_last;
    logic [63:0]        row_word;
    logic [63:0]        w_word;
    logic signed [15:0] prod [8];
    logic signed [31:0] partial;
    logic signed [31:0] acc_next;

    // The lower K bits are zero by contract and M is duplicated on
    // Img2Col_OutMatrix_Row; they are accepted but carry no information.
    logic unused_cfg;
    assign unused_cfg = ^{Img2Col_OutMatrix_Row, Img2Col_WeightMatrix_Row[2:0],
                          GemmInstru_WIDTH[2:0]};

    assign s_axis_s2mm_tready = (state == S_LOAD_W) || (state == S_LOAD_ROW);
    assign m_axis_mm2s_tvalid = out_valid;
    assign m_axis_mm2s_tdata  = out_data;
    assign m_axis_mm2s_tlast  = out_last;
    assign m_axis_mm2s_tkeep  = 8'hFF;

    assign in_hs    = s_axis_s2mm_tvalid && s_axis_s2mm_tready;
    assign out_hs   = out_valid && m_axis_mm2s_tready;
    assign w_last_k = (kcnt == w_k8 - 13'd1);
    assign a_last_k = (kcnt == a_k8 - 13'd1);
    assign n_last   = (ncnt == o_n - 16'd1);
    assign m_last   = (mcnt == m_rows - 16'd1);

    // Weights are walked sequentially: output n, beat k lives at n*K/8+k,
    // so a single incrementing address serves both load and compute.
    assign row_word = rbuf[kcnt[RW-1:0]];
    assign w_word   = wbuf[addr];

    // Eight signed 8x8 products summed into one 32-bit partial per beat.
    always_comb begin
        // NOTE: every always_comb output gets a default before any use, so no
        // path through the block can leave it holding a stale value (latch).
        partial = 32'sd0;
        for (int i = 0; i < 8; i++) begin
            prod[i] = $signed(row_word[8*i +: 8]) * $signed(w_word[8*i +: 8]);
            partial = partial + 32'(prod[i]);
        end
        acc_next = ((kcnt == 13'd0) ? 32'sd0 : acc) + partial;
    end

    // Weight buffer write port, filled column by column during LOAD_W.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; their contents are
        // always written before they are read within a job.
        if (state == S_LOAD_W && in_hs)
            wbuf[addr] <= s_axis_s2mm_tdata;
    end

    // Activation row buffer write port, one row per LOAD_ROW visit.
    always_ff @(posedge clk) begin
        if (state == S_LOAD_ROW && in_hs)
            rbuf[kcnt[RW-1:0]] <= s_axis_s2mm_tdata;
    end

    // Job sequencer, accumulator and single-entry output register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset) begin
            state     <= S_IDLE;
            w_n       <= '0;
            w_k8      <= '0;
            o_n       <= '0;
            a_k8      <= '0;
            m_rows    <= '0;
            kcnt      <= '0;
            ncnt      <= '0;
            mcnt      <= '0;
            addr      <= '0;
            drain     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (Control_start && !Control_Switch_Conv) begin
                        w_n    <= Img2Col_OutFeature_Channel;
                        w_k8   <= Img2Col_WeightMatrix_Row[15:3];
                        o_n    <= Img2Col_OutMatrix_Col;
                        a_k8   <= GemmInstru_WIDTH[15:3];
                        m_rows <= GemmInstru_HEIGHT;
                        kcnt   <= '0;
                        ncnt   <= '0;
                        mcnt   <= '0;
                        addr   <= '0;
                        drain  <= 1'b0;
                        acc    <= '0;
                        state  <= S_LOAD_W;
                    end
                end
                S_LOAD_W: begin
                    if (in_hs) begin
                        addr <= addr + 1'b1;
                        if (w_last_k) begin
                            kcnt <= '0;
                            if (ncnt == w_n - 16'd1) begin
                                ncnt  <= '0;
                                addr  <= '0;
                                state <= S_LOAD_ROW;
                            end else begin
                                ncnt <= ncnt + 16'd1;
                            end
                        end else begin
                            kcnt <= kcnt + 13'd1;
                        end
                    end
                end
                S_LOAD_ROW: begin
                    if (in_hs) begin
                        if (a_last_k) begin
                            kcnt  <= '0;
                            state <= S_COMPUTE;
                        end else begin
                            kcnt <= kcnt + 13'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (drain) begin
                        // Last result of the job is parked; leave once it is taken.
                        if (out_hs) begin
                            drain <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (!out_valid) begin
                        acc  <= acc_next;
                        addr <= addr + 1'b1;
                        if (a_last_k) begin
                            kcnt      <= '0;
                            out_data  <= {{32{acc_next[31]}}, acc_next};
                            out_valid <= 1'b1;
                            out_last  <= n_last && m_last;
                            if (n_last) begin
                                ncnt <= '0;
                                if (m_last) begin
                                    drain <= 1'b1;
                                end else begin
                                    mcnt  <= mcnt + 16'd1;
                                    addr  <= '0;
                                    state <= S_LOAD_ROW;
                                end
                            end else begin
                                ncnt <= ncnt + 16'd1;
                            end
                        end else begin
                            kcnt <= kcnt + 13'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_gemm_unit.sv
// tb_conv_gemm_unit: randomized self-checking bench for conv_gemm_unit.
// Expected results come from a plain triple-loop matrix product.
module tb_conv_gemm_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Control_start;
    logic        Control_Switch_Conv;
    logic [15:0] Img2Col_OutFeature_Channel;
    logic [15:0] Img2Col_WeightMatrix_Row;
    logic [15:0] Img2Col_OutMatrix_Col;
    logic [15:0] Img2Col_OutMatrix_Row;
    logic [15:0] GemmInstru_WIDTH;
    logic [15:0] GemmInstru_HEIGHT;
    logic [63:0] s_axis_s2mm_tdata;
    logic        s_axis_s2mm_tvalid;
    logic        s_axis_s2mm_tready;
    logic [63:0] m_axis_mm2s_tdata;
    logic        m_axis_mm2s_tvalid;
    logic        m_axis_mm2s_tready;
    logic [7:0]  m_axis_mm2s_tkeep;
    logic        m_axis_mm2s_tlast;

    always #5 clk = ~clk;

    conv_gemm_unit #(.WBUF_DEPTH(256), .ROW_DEPTH(16)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .Control_start              (Control_start),
        .Control_Switch_Conv        (Control_Switch_Conv),
        .Img2Col_OutFeature_Channel (Img2Col_OutFeature_Channel),
        .Img2Col_WeightMatrix_Row   (Img2Col_WeightMatrix_Row),
        .Img2Col_OutMatrix_Col      (Img2Col_OutMatrix_Col),
        .Img2Col_OutMatrix_Row      (Img2Col_OutMatrix_Row),
        .GemmInstru_WIDTH           (GemmInstru_WIDTH),
        .GemmInstru_HEIGHT          (GemmInstru_HEIGHT),
        .s_axis_s2mm_tdata          (s_axis_s2mm_tdata),
        .s_axis_s2mm_tvalid         (s_axis_s2mm_tvalid),
        .s_axis_s2mm_tready         (s_axis_s2mm_tready),
        .m_axis_mm2s_tdata          (m_axis_mm2s_tdata),
        .m_axis_mm2s_tvalid         (m_axis_mm2s_tvalid),
        .m_axis_mm2s_tready         (m_axis_mm2s_tready),
        .m_axis_mm2s_tkeep          (m_axis_mm2s_tkeep),
        .m_axis_mm2s_tlast          (m_axis_mm2s_tlast)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int M, N, K;
    byte A [32][128];
    byte B [128][32];
    logic [63:0] in_q  [$];
    logic [64:0] exp_q [$];
    int row0_cyc;
    int in_beats;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // mode 0: all ones, 1: all -128, 2: random
    task automatic fill(input int mode);
        for (int k = 0; k < K; k++) begin
            for (int n = 0; n < N; n++)
                B[k][n] = (mode == 0) ? 8'sd1 : (mode == 1) ? -8'sd128 : byte'($urandom);
            for (int m = 0; m < M; m++)
                A[m][k] = (mode == 0) ? 8'sd1 : (mode == 1) ? -8'sd128 : byte'($urandom);
        end
    endtask

    // Builds the input beat stream and the expected output stream.
    task automatic build();
        logic [63:0] w;
        int s;
        in_q.delete();
        exp_q.delete();
        for (int n = 0; n < N; n++)
            for (int j = 0; j < K / 8; j++) begin
                for (int i = 0; i < 8; i++) w[8*i +: 8] = B[8*j+i][n];
                in_q.push_back(w);
            end
        for (int m = 0; m < M; m++)
            for (int j = 0; j < K / 8; j++) begin
                for (int i = 0; i < 8; i++) w[8*i +: 8] = A[m][8*j+i];
                in_q.push_back(w);
            end
        for (int m = 0; m < M; m++)
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < K; k++) s += int'(A[m][k]) * int'(B[k][n]);
                exp_q.push_back({(m == M - 1) && (n == N - 1), 64'(longint'(s))});
            end
        Img2Col_OutFeature_Channel = 16'(N);
        Img2Col_WeightMatrix_Row   = 16'(K);
        Img2Col_OutMatrix_Col      = 16'(N);
        Img2Col_OutMatrix_Row      = 16'(M);
        GemmInstru_WIDTH           = 16'(K);
        GemmInstru_HEIGHT          = 16'(M);
    endtask

    task automatic pulse_start(input int hold);
        @(negedge clk);
        Control_start = 1'b1;
        repeat (hold) @(negedge clk);
        Control_start = 1'b0;
    endtask

    task automatic drive(input int count, input bit gaps);
        int idx = 0;
        int budget = 0;
        in_beats = 0;
        while (idx < count && budget < 30000) begin
            @(negedge clk);
            budget++;
            if (gaps && ((cyc % 513) < 2 || $urandom_range(0, 5) == 0)) begin
                s_axis_s2mm_tvalid = 1'b0;
                s_axis_s2mm_tdata  = {$urandom, $urandom};
            end else begin
                s_axis_s2mm_tvalid = 1'b1;
                s_axis_s2mm_tdata  = in_q[idx];
            end
            #1;
            if (s_axis_s2mm_tvalid && s_axis_s2mm_tready) begin
                if (idx == N * K / 8 + K / 8 - 1) row0_cyc = cyc;
                idx++;
                in_beats++;
            end
        end
        @(negedge clk);
        s_axis_s2mm_tvalid = 1'b0;
        if (idx < count) check("drive_timeout", 64'(idx), 64'(count));
    endtask

    task automatic collect(input bit rand_ready, input bit chk_timing);
        int got = 0;
        int budget = 0;
        int rise0 = 0;
        int total = M * N;
        bit stalled = 1'b0;
        bit prev = 1'b0;
        logic [63:0] held_d;
        logic held_l;
        logic [64:0] e;
        while (got < total && budget < 40000) begin
            @(negedge clk);
            budget++;
            m_axis_mm2s_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_axis_mm2s_tvalid) begin
                if (stalled) begin
                    check("stall_data", m_axis_mm2s_tdata, held_d);
                    check("stall_last", 64'(m_axis_mm2s_tlast), 64'(held_l));
                end
                if (!prev && chk_timing) begin
                    if (got == 0) begin
                        check("first_latency", 64'(cyc - row0_cyc), 64'(K / 8 + 1));
                        rise0 = cyc;
                    end else if (got == 1) begin
                        check("output_gap", 64'(cyc - rise0), 64'(K / 8 + 1));
                    end
                end
                if (m_axis_mm2s_tready) begin
                    e = exp_q.pop_front();
                    check($sformatf("c%0d_data", got), m_axis_mm2s_tdata, e[63:0]);
                    check($sformatf("c%0d_last", got), 64'(m_axis_mm2s_tlast), 64'(e[64]));
                    check("tkeep", 64'(m_axis_mm2s_tkeep), 64'hFF);
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = m_axis_mm2s_tdata;
                    held_l  = m_axis_mm2s_tlast;
                end
            end
            prev = m_axis_mm2s_tvalid && !m_axis_mm2s_tready;
        end
        check("out_count", 64'(got), 64'(total));
        @(posedge clk);
        #1;
        m_axis_mm2s_tready = 1'b0;
        check("idle_tready", 64'(s_axis_s2mm_tready), 64'd0);
        check("idle_tvalid", 64'(m_axis_mm2s_tvalid), 64'd0);
    endtask

    task automatic run_job(input int hold, input bit gaps, input bit rand_ready, input bit chk_timing);
        build();
        fork
            pulse_start(hold);
            drive(in_q.size(), gaps);
            collect(rand_ready, chk_timing);
        join
        check("in_beats", 64'(in_beats), 64'(N * K / 8 + M * K / 8));
    endtask

    initial begin
        int cnt;
        int w;
        reset = 1'b0;
        Control_start = 1'b0;
        Control_Switch_Conv = 1'b0;
        s_axis_s2mm_tvalid = 1'b0;
        s_axis_s2mm_tdata = '0;
        m_axis_mm2s_tready = 1'b0;
        M = 1; N = 1; K = 8;
        build();
        repeat (3) @(negedge clk);
        check("rst_tready", 64'(s_axis_s2mm_tready), 64'd0);
        check("rst_tvalid", 64'(m_axis_mm2s_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_mm2s_tlast), 64'd0);
        check("rst_tdata", m_axis_mm2s_tdata, 64'd0);
        reset = 1'b1;

        // Conv mode start is ignored.
        @(negedge clk);
        Control_Switch_Conv = 1'b1;
        Control_start = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            cnt += int'(s_axis_s2mm_tready);
        end
        Control_start = 1'b0;
        Control_Switch_Conv = 1'b0;
        check("conv_ignored", 64'(cnt), 64'd0);

        M = 23; N = 16; K = 16; fill(0); run_job(1, 0, 0, 1);

        M = 1; N = 2; K = 8;
        for (int k = 0; k < 8; k++) begin
            B[k][0] = byte'(k + 1);
            B[k][1] = -8'sd1;
            A[0][k] = byte'(k + 1);
        end
        run_job(1, 0, 0, 1);

        M = 1; N = 1; K = 128; fill(1); run_job(1, 0, 0, 1);

        M = 5; N = 8; K = 32; fill(2);
        run_job(1, 0, 0, 1);
        run_job(1, 1, 1, 0);

        for (int r = 0; r < 3; r++) begin
            K = 8 * $urandom_range(1, 16);
            N = $urandom_range(1, (256 / (K / 8) > 32) ? 32 : 256 / (K / 8));
            M = $urandom_range(1, 6);
            fill(2);
            run_job(1, 1, 1, 0);
        end

        // Start held long, then re-pulsed on the first IDLE cycle.
        M = 3; N = 4; K = 16; fill(2);
        run_job(20, 0, 0, 0);
        run_job(1, 0, 0, 0);
        m_axis_mm2s_tready = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            cnt += int'(m_axis_mm2s_tvalid) + int'(s_axis_s2mm_tready);
        end
        m_axis_mm2s_tready = 1'b0;
        check("no_third_job", 64'(cnt), 64'd0);

        // Reset while a result is parked in COMPUTE.
        M = 2; N = 2; K = 128; fill(2); build();
        fork
            pulse_start(1);
            drive(N * K / 8 + K / 8, 0);
        join
        w = 0;
        while (!m_axis_mm2s_tvalid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("pre_reset_valid", 64'(m_axis_mm2s_tvalid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_axis_mm2s_tvalid), 64'd0);
        check("mid_rst_tready", 64'(s_axis_s2mm_tready), 64'd0);
        check("mid_rst_tdata", m_axis_mm2s_tdata, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_axis_mm2s_tready = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            cnt += int'(m_axis_mm2s_tvalid) + int'(s_axis_s2mm_tready);
        end
        m_axis_mm2s_tready = 1'b0;
        check("post_rst_quiet", 64'(cnt), 64'd0);
        M = 2; N = 3; K = 24; fill(2); run_job(1, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
